// File: rtl/lenet_predict_udiv_13ns_11ns_13_seq.sv
// Sequential restoring radix-2 unsigned divider: one quotient bit per cycle, MSB first.
// Optional div_zero output flag when LENET_DIV_ZERO_FLAG_EN is defined.
module lenet_predict_udiv_13ns_11ns_13_seq #(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 14,
    parameter int din0_WIDTH = 13,
    parameter int din1_WIDTH = 11,
    parameter int dout_WIDTH = 13
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  ap_start,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  ap_idle,
    output logic                  ap_done,
    output logic [dout_WIDTH-1:0] dout,
    output logic [din1_WIDTH-1:0] rem
`ifdef LENET_DIV_ZERO_FLAG_EN
    ,
    output logic                  div_zero
`endif
);

    localparam int PW    = din1_WIDTH + 1;
    localparam int CNT_W = $clog2(din0_WIDTH);

    // Quotient and dividend share one width; any other combination is not a supported build.
    if (dout_WIDTH != din0_WIDTH || NUM_STAGE != din0_WIDTH + 1 || ID < 0) begin : g_cfg_unsupported
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_reg,    state_next;
    logic [din0_WIDTH-1:0]   dividend_reg, dividend_next;
    logic [din1_WIDTH-1:0]   divisor_reg,  divisor_next;
    logic [PW-1:0]           partial_reg,  partial_next;
    logic [dout_WIDTH-1:0]   quot_reg,     quot_next;
    logic [CNT_W-1:0]        cnt_reg,      cnt_next;
    logic [dout_WIDTH-1:0]   dout_reg,     dout_next;
    logic [din1_WIDTH-1:0]   rem_reg,      rem_next;
    logic                    zero_reg,     zero_next;

    logic [PW-1:0]           shifted;
    logic [PW-1:0]           diff;
    logic                    fits;
    logic                    accept;

    // Partial remainder stays below the divisor, so dropping its MSB on the shift loses nothing
    // except in the divide-by-zero case, where it leaves din0's low bits as the remainder.
    assign shifted = {partial_reg[PW-2:0], dividend_reg[din0_WIDTH-1]};
    assign fits    = shifted >= {1'b0, divisor_reg};
    assign diff    = shifted - {1'b0, divisor_reg};
    assign accept  = ap_start && (state_reg == IDLE || state_reg == DONE);

    always_comb begin
        state_next    = state_reg;
        dividend_next = dividend_reg;
        divisor_next  = divisor_reg;
        partial_next  = partial_reg;
        quot_next     = quot_reg;
        cnt_next      = cnt_reg;
        dout_next     = dout_reg;
        rem_next      = rem_reg;
        zero_next     = zero_reg;

        case (state_reg)
            IDLE: begin
                state_next = IDLE;
            end
            BUSY: begin
                dividend_next = dividend_reg << 1;
                partial_next  = fits ? diff : shifted;
                quot_next     = {quot_reg[dout_WIDTH-2:0], fits};
                cnt_next      = cnt_reg - CNT_W'(1);
                if (cnt_reg == '0) begin
                    state_next = DONE;
                    dout_next  = quot_next;
                    rem_next   = partial_next[din1_WIDTH-1:0];
                    zero_next  = (divisor_reg == '0);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // New request from IDLE, or back-to-back from DONE
        if (accept) begin
            state_next    = BUSY;
            dividend_next = din0;
            divisor_next  = din1;
            partial_next  = '0;
            quot_next     = '0;
            cnt_next      = CNT_W'(din0_WIDTH - 1);
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_reg    <= IDLE;
            dividend_reg <= '0;
            divisor_reg  <= '0;
            partial_reg  <= '0;
            quot_reg     <= '0;
            cnt_reg      <= '0;
            dout_reg     <= '0;
            rem_reg      <= '0;
            zero_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            dividend_reg <= dividend_next;
            divisor_reg  <= divisor_next;
            partial_reg  <= partial_next;
            quot_reg     <= quot_next;
            cnt_reg      <= cnt_next;
            dout_reg     <= dout_next;
            rem_reg      <= rem_next;
            zero_reg     <= zero_next;
        end
    end

    assign ap_idle = (state_reg == IDLE);
    assign ap_done = (state_reg == DONE);
    assign dout    = dout_reg;
    assign rem     = rem_reg;

`ifdef LENET_DIV_ZERO_FLAG_EN
    assign div_zero = zero_reg;
`else
    // Flag is only exported when the feature is enabled.
    logic unused_zero;
    assign unused_zero = zero_reg;
`endif

endmodule

// File: tb/tb_lenet_predict_udiv_13ns_11ns_13_seq.sv
// Directed bench for the sequential 13/11-bit unsigned divider.
module tb_lenet_predict_udiv_13ns_11ns_13_seq;

    logic        ap_clk = 1'b0;
    logic        ap_rst = 1'b1;
    logic        ap_start = 1'b0;
    logic [12:0] din0 = '0;
    logic [10:0] din1 = '0;
    logic        ap_idle;
    logic        ap_done;
    logic [12:0] dout;
    logic [10:0] rem;
`ifdef LENET_DIV_ZERO_FLAG_EN
    logic        div_zero;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 ap_clk = ~ap_clk;

    lenet_predict_udiv_13ns_11ns_13_seq dut (
        .ap_clk   (ap_clk),
        .ap_rst   (ap_rst),
        .ap_start (ap_start),
        .din0     (din0),
        .din1     (din1),
        .ap_idle  (ap_idle),
        .ap_done  (ap_done),
        .dout     (dout),
        .rem      (rem)
`ifdef LENET_DIV_ZERO_FLAG_EN
        ,
        .div_zero (div_zero)
`endif
    );

    task automatic check(input string tag, input int got, input int exp_v);
        checks++;
        if (got != exp_v) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d at %0t", tag, got, exp_v, $time);
        end
    endtask

    // Called at a negedge in IDLE (cycle 0); returns at the negedge of cycle 15.
    task automatic run_div(input int a, input int b, input int q, input int r, input bit poke);
        ap_start = 1'b1;
        din0 = 13'(a);
        din1 = 11'(b);
        for (int c = 1; c <= 15; c++) begin
            @(negedge ap_clk);
            check("done", int'(ap_done), (c == 14) ? 1 : 0);
            check("idle", int'(ap_idle), (c == 15) ? 1 : 0);
            if (c == 14) begin
                check("dout", int'(dout), q);
                check("rem", int'(rem), r);
`ifdef LENET_DIV_ZERO_FLAG_EN
                check("div_zero", int'(div_zero), (b == 0) ? 1 : 0);
`endif
                $display("div %0d/%0d -> q=%0d r=%0d", a, b, dout, rem);
            end
            if (c == 1) ap_start = 1'b0;
            if (poke && c == 5) begin
                ap_start = 1'b1;
                din0 = 13'd1;
                din1 = 11'd1;
            end
            if (poke && c == 6) ap_start = 1'b0;
        end
    endtask

    initial begin
        bit saw_done;
        repeat (3) @(negedge ap_clk);
        check("rst_idle", int'(ap_idle), 1);
        check("rst_done", int'(ap_done), 0);
        check("rst_dout", int'(dout), 0);
        check("rst_rem", int'(rem), 0);
        ap_rst = 1'b0;
        @(negedge ap_clk);

        run_div(100, 7, 14, 2, 1'b0);
        run_div(8191, 1, 8191, 0, 1'b0);
        run_div(5, 2047, 0, 5, 1'b0);
        run_div(1234, 0, 8191, 1234, 1'b0);
        run_div(0, 5, 0, 0, 1'b0);
        run_div(2047, 2047, 1, 0, 1'b0);
        run_div(6000, 123, 48, 96, 1'b0);
        run_div(200, 9, 22, 2, 1'b1);

        // Back-to-back: start held, operands changed in the DONE cycle
        ap_start = 1'b1;
        din0 = 13'd4095;
        din1 = 11'd64;
        for (int c = 1; c <= 29; c++) begin
            @(negedge ap_clk);
            check("b2b_done", int'(ap_done), (c == 14 || c == 28) ? 1 : 0);
            check("b2b_idle", int'(ap_idle), (c == 29) ? 1 : 0);
            if (c == 14) begin
                check("b2b_dout1", int'(dout), 63);
                check("b2b_rem1", int'(rem), 63);
                $display("b2b 4095/64 -> q=%0d r=%0d", dout, rem);
                din0 = 13'd4096;
            end
            if (c == 28) begin
                check("b2b_dout2", int'(dout), 64);
                check("b2b_rem2", int'(rem), 0);
                $display("b2b 4096/64 -> q=%0d r=%0d", dout, rem);
                ap_start = 1'b0;
            end
        end

        // Reset in the middle of a divide aborts it
        ap_start = 1'b1;
        din0 = 13'd300;
        din1 = 11'd7;
        saw_done = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge ap_clk);
            if (c == 1) ap_start = 1'b0;
            if (c == 7) begin
                check("abort_idle", int'(ap_idle), 1);
                check("abort_dout", int'(dout), 0);
                check("abort_rem", int'(rem), 0);
                ap_rst = 1'b0;
            end
            if (ap_done) saw_done = 1'b1;
            if (c == 6) ap_rst = 1'b1;
        end
        check("abort_no_done", int'(saw_done), 0);
        $display("abort at cycle 6 -> done seen=%0d", saw_done);

        // Start coincident with reset is ignored
        ap_rst = 1'b1;
        ap_start = 1'b1;
        @(negedge ap_clk);
        ap_rst = 1'b0;
        ap_start = 1'b0;
        @(negedge ap_clk);
        check("rst_start_idle", int'(ap_idle), 1);
        repeat (14) @(negedge ap_clk);
        check("rst_start_done", int'(ap_done), 0);
        $display("start with reset -> idle=%0d", ap_idle);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
